// File: rtl/weight_mux_pkg.sv
// Shared types and width helpers for the weight-proxy word multiplexer.
package weight_mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Width of a select value. It is never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // The sweep index must be able to hold NUM_INPUTS itself.
    // That value means every word has been handed out.
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/word_select_nto1.sv
// Combinational indexed word pick from a packed bus.
// An index past the last word returns zero.
module word_select_nto1
    import weight_mux_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int WORD_SIZE = 16,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_WORDS*WORD_SIZE-1:0] bus,
    input  logic [IDX_W-1:0]               idx,
    output logic [WORD_SIZE-1:0]           word
);

    always_comb begin
        // NOTE: assign a default first so every path drives word and no latch is inferred.
        word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx == IDX_W'(k)) word = bus[k*WORD_SIZE +: WORD_SIZE];
        end
    end

endmodule

// File: rtl/weight_mux_sweep_nto1.sv
// Registered N-to-1 word mux with a valid/ready output stage and a full-bus SWEEP mode.
// Optional SEL_RANGE_CHECK_EN rejects out-of-range select loads and pulses sel_err.
module weight_mux_sweep_nto1
    import weight_mux_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    parameter  int WORD_SIZE  = 16,
    localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_INPUTS*WORD_SIZE-1:0] in_bus,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SEL_W-1:0]                sel_in,
    input  logic                            sel_load,
    input  logic                            sweep_start,
    output logic [WORD_SIZE-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            sweep_busy
`ifdef SEL_RANGE_CHECK_EN
    ,
    output logic                            sel_err
`endif
);

    localparam int               IDX_W    = idx_width(NUM_INPUTS);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_INPUTS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);

    state_t                          state, state_next;
    logic [SEL_W-1:0]                sel_reg;
    logic [IDX_W-1:0]                idx;
    logic [NUM_INPUTS*WORD_SIZE-1:0] snapshot;
    logic [WORD_SIZE-1:0]            direct_word;
    logic [WORD_SIZE-1:0]            sweep_word;
    logic                            pop;
    logic                            accept;
    logic                            start_sweep;
    logic                            capture;

    word_select_nto1 #(
        .NUM_WORDS(NUM_INPUTS), .WORD_SIZE(WORD_SIZE), .IDX_W(SEL_W)
    ) u_direct_sel (
        .bus (in_bus),
        .idx (sel_reg),
        .word(direct_word)
    );

    word_select_nto1 #(
        .NUM_WORDS(NUM_INPUTS), .WORD_SIZE(WORD_SIZE), .IDX_W(IDX_W)
    ) u_sweep_sel (
        .bus (snapshot),
        .idx (idx),
        .word(sweep_word)
    );

    assign pop         = out_valid & out_ready;
    assign accept      = in_valid & in_ready;
    assign start_sweep = accept & sweep_start;
    assign capture     = accept & ~sweep_start;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_sweep) state_next = SWEEP;
            SWEEP:   if (pop && idx == IDX_END) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        sweep_busy = 1'b0;
        case (state)
            IDLE:    in_ready   = ~out_valid | out_ready;
            SWEEP:   sweep_busy = 1'b1;
            default: ;
        endcase
    end

    // Output stage. A sweep streams from the snapshot, so live in_bus changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            idx       <= '0;
            snapshot  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_sweep) begin
                        snapshot  <= in_bus;
                        out_data  <= in_bus[WORD_SIZE-1:0];
                        out_valid <= 1'b1;
                        out_last  <= (NUM_INPUTS == 1);
                        idx       <= IDX_W'(1);
                    end else if (capture) begin
                        out_data  <= direct_word;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (pop) begin
                        if (idx == IDX_END) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= '0;
                        end else begin
                            out_data <= sweep_word;
                            out_last <= (idx == IDX_LAST);
                            idx      <= idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEL_RANGE_CHECK_EN
    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(NUM_INPUTS);

    logic sel_in_range;
    assign sel_in_range = {1'b0, sel_in} < SEL_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= sel_load & ~sel_in_range;
            if (sel_load && sel_in_range) sel_reg <= sel_in;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sel_reg <= '0;
        else if (sel_load) sel_reg <= sel_in;
    end
`endif

endmodule

// File: tb/tb_weight_mux_sweep_nto1.sv
// Self-checking bench for weight_mux_sweep_nto1: table-driven captures plus a scoreboard
// of expected output words, and a second NUM_INPUTS=5 instance for select range handling.
module tb_weight_mux_sweep_nto1;

    localparam logic [63:0] DEFAULT_BUS = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    localparam logic [63:0] ALT_BUS     = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    localparam logic [79:0] BUS5        = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

    typedef struct {
        logic [63:0] bus;
        logic [1:0]  sel;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] exp;
        logic        err;
    } vec5_t;

    typedef struct {
        logic [15:0] word;
        logic        last;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [63:0] in_bus;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel_in;
    logic        sel_load;
    logic        sweep_start;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        sweep_busy;

    logic [79:0] in_bus5;
    logic        in_valid5;
    logic        in_ready5;
    logic [2:0]  sel_in5;
    logic        sel_load5;
    logic [15:0] out_data5;
    logic        out_valid5;
    logic        out_last5;
    logic        sweep_busy5;
`ifdef SEL_RANGE_CHECK_EN
    logic        sel_err;
    logic        sel_err5;
`endif

    int  checks   = 0;
    int  failures = 0;
    sb_t sb[$];

    weight_mux_sweep_nto1 #(.NUM_INPUTS(4), .WORD_SIZE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_bus     (in_bus),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel_in     (sel_in),
        .sel_load   (sel_load),
        .sweep_start(sweep_start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .sweep_busy (sweep_busy)
`ifdef SEL_RANGE_CHECK_EN
        ,
        .sel_err    (sel_err)
`endif
    );

    weight_mux_sweep_nto1 #(.NUM_INPUTS(5), .WORD_SIZE(16)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .in_bus     (in_bus5),
        .in_valid   (in_valid5),
        .in_ready   (in_ready5),
        .sel_in     (sel_in5),
        .sel_load   (sel_load5),
        .sweep_start(1'b0),
        .out_data   (out_data5),
        .out_valid  (out_valid5),
        .out_ready  (1'b1),
        .out_last   (out_last5),
        .sweep_busy (sweep_busy5)
`ifdef SEL_RANGE_CHECK_EN
        ,
        .sel_err    (sel_err5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] word, input logic last);
        sb_t e;
        e.word = word;
        e.last = last;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, score any pop, then advance one clock.
    task automatic tick();
        sb_t e;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got %0h expected no output", out_data);
            end else begin
                e = sb.pop_front();
                check("sb_data", 64'(out_data), 64'(e.word));
                check("sb_last", 64'(out_last), 64'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[6];
        vec5_t vecs5[4];

        vecs[0] = '{DEFAULT_BUS, 2'd0, 16'h1111};
        vecs[1] = '{DEFAULT_BUS, 2'd2, 16'h3333};
        vecs[2] = '{DEFAULT_BUS, 2'd3, 16'h4444};
        vecs[3] = '{{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, 2'd1, 16'hCAFE};
        vecs[4] = '{{64{1'b1}}, 2'd3, 16'hFFFF};
        vecs[5] = '{{16'h0000, 16'h0000, 16'h0000, 16'h8001}, 2'd0, 16'h8001};

`ifdef SEL_RANGE_CHECK_EN
        vecs5[0] = '{3'd4, 16'h5555, 1'b0};
        vecs5[1] = '{3'd6, 16'h5555, 1'b1};
        vecs5[2] = '{3'd5, 16'h5555, 1'b1};
        vecs5[3] = '{3'd1, 16'h2222, 1'b0};
`else
        vecs5[0] = '{3'd4, 16'h5555, 1'b0};
        vecs5[1] = '{3'd6, 16'h0000, 1'b0};
        vecs5[2] = '{3'd5, 16'h0000, 1'b0};
        vecs5[3] = '{3'd1, 16'h2222, 1'b0};
`endif

        rst         = 1'b1;
        in_bus      = DEFAULT_BUS;
        in_valid    = 1'b0;
        sel_in      = '0;
        sel_load    = 1'b0;
        sweep_start = 1'b0;
        out_ready   = 1'b1;
        in_bus5     = BUS5;
        in_valid5   = 1'b0;
        sel_in5     = '0;
        sel_load5   = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_sweep_busy", 64'(sweep_busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_in_ready5", 64'(in_ready5), 64'(1));
`ifdef SEL_RANGE_CHECK_EN
        check("rst_sel_err", 64'(sel_err5), 64'(0));
`endif

        // Direct captures from the vector table.
        for (int i = 0; i < 6; i++) begin
            in_bus   = vecs[i].bus;
            sel_in   = vecs[i].sel;
            sel_load = 1'b1;
            tick();
            sel_load = 1'b0;
            in_valid = 1'b1;
            push(vecs[i].exp, 1'b0);
            tick();
            in_valid = 1'b0;
            check("vec_out_valid", 64'(out_valid), 64'(1));
            check("vec_out_data", 64'(out_data), 64'(vecs[i].exp));
            tick();
            check("vec_drained", 64'(out_valid), 64'(0));
        end

        // A capture in the same cycle as sel_load uses the old select.
        in_bus   = DEFAULT_BUS;
        sel_in   = 2'd2;
        sel_load = 1'b1;
        tick();
        sel_in   = 2'd3;
        in_valid = 1'b1;
        push(16'h3333, 1'b0);
        tick();
        sel_load = 1'b0;
        push(16'h4444, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();

        // Backpressure: stalled word holds and a rival capture is refused.
        sel_in    = 2'd1;
        sel_load  = 1'b1;
        tick();
        sel_load  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        push(16'h2222, 1'b0);
        tick();
        in_bus = ALT_BUS;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_out_data", 64'(out_data), 64'(16'h2222));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'(1));
        push(16'hBBBB, 1'b0);
        tick();
        in_valid = 1'b0;
        check("bp_new_data", 64'(out_data), 64'(16'hBBBB));
        tick();
        check("bp_drained", 64'(out_valid), 64'(0));

        // Sweep with live bus changes and a refused restart.
        in_bus      = DEFAULT_BUS;
        in_valid    = 1'b1;
        sweep_start = 1'b1;
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        push(16'h3333, 1'b0);
        push(16'h4444, 1'b1);
        tick();
        in_bus = ALT_BUS;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("sw_busy", 64'(sweep_busy), 64'(1));
            check("sw_in_ready", 64'(in_ready), 64'(0));
            tick();
        end
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        #1;
        check("sw_done_busy", 64'(sweep_busy), 64'(0));
        check("sw_done_valid", 64'(out_valid), 64'(0));
        tick();
        check("sw_no_restart", 64'(out_valid), 64'(0));

        // Reset mid-sweep while stalled on word 2.
        in_bus      = DEFAULT_BUS;
        in_valid    = 1'b1;
        sweep_start = 1'b1;
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        tick();
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        check("rs_stall_data", 64'(out_data), 64'(16'h3333));
        check("rs_stall_busy", 64'(sweep_busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rs_async_valid", 64'(out_valid), 64'(0));
        check("rs_async_busy", 64'(sweep_busy), 64'(0));
        check("rs_async_data", 64'(out_data), 64'(0));
        check("rs_async_last", 64'(out_last), 64'(0));
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        sel_in    = 2'd0;
        sel_load  = 1'b1;
        tick();
        sel_load = 1'b0;
        in_valid = 1'b1;
        push(16'h1111, 1'b0);
        tick();
        in_valid = 1'b0;
        check("rs_capture_data", 64'(out_data), 64'(16'h1111));
        tick();

        // Select range handling on the five-word instance.
        for (int i = 0; i < 4; i++) begin
            sel_in5   = vecs5[i].sel;
            sel_load5 = 1'b1;
            tick();
            sel_load5 = 1'b0;
`ifdef SEL_RANGE_CHECK_EN
            check("rc_sel_err", 64'(sel_err5), 64'(vecs5[i].err));
`endif
            in_valid5 = 1'b1;
            tick();
            in_valid5 = 1'b0;
`ifdef SEL_RANGE_CHECK_EN
            check("rc_sel_err_clear", 64'(sel_err5), 64'(0));
`endif
            check("rc_out_valid", 64'(out_valid5), 64'(1));
            check("rc_out_data", 64'(out_data5), 64'(vecs5[i].exp));
            tick();
        end

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
